// File: rtl/alarm_sequencer.sv
// alarm_sequencer
//   Alarm state machine for the alarm clock. It compares the running time
//   with the programmed alarm time and raises a ringing condition. It also
//   sequences the snooze and auto-stop intervals, which are timed by the
//   1 Hz sec_tick.
//
// Ports
//   clk_in        system clock (rising edge)
//   reset         synchronous, active-high reset
//   sec_tick      1-cycle pulse once per second
//   cur_hour/min/sec    running time
//   alarm_hour/min      programmed alarm time
//   alarm_enable  level; 0 forces OFF from any state
//   snooze_btn    1-cycle pulse
//   stop_btn      1-cycle pulse
//   armed/ringing/snoozing  registered one-hot status of ARMED/RINGING/SNOOZE
//   buzzer        beep pattern; 0 outside RINGING
//   snooze_cnt    snoozes used in the current alarm event
//   state_dbg     current FSM state encoding (OFF=0, ARMED=1, RINGING=2, SNOOZE=3)
//
// Handshake: there are no valid/ready pairs. The button and tick inputs are
// single-cycle pulses that are sampled on the rising clock edge. Every output
// is a registered level.
module alarm_sequencer #(
  parameter int SNOOZE_SEC = 300,
  parameter int RING_SEC   = 600,
  parameter int MAX_SNOOZE = 3,
  localparam int CNT_W = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1,
  localparam int TMR_W = $clog2(((SNOOZE_SEC > RING_SEC) ? SNOOZE_SEC : RING_SEC) + 1)
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             sec_tick,
  input  logic [4:0]       cur_hour,
  input  logic [5:0]       cur_min,
  input  logic [5:0]       cur_sec,
  input  logic [4:0]       alarm_hour,
  input  logic [5:0]       alarm_min,
  input  logic             alarm_enable,
  input  logic             snooze_btn,
  input  logic             stop_btn,
  output logic             armed,
  output logic             ringing,
  output logic             snoozing,
  output logic             buzzer,
  output logic [CNT_W-1:0] snooze_cnt,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZE  = 2'd3
  } state_t;

  localparam logic [TMR_W-1:0] RING_LAST   = TMR_W'(RING_SEC - 1);
  localparam logic [TMR_W-1:0] SNOOZE_LAST = TMR_W'(SNOOZE_SEC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(MAX_SNOOZE);

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               buzzer_q, buzzer_d;
  logic               match_q, match_d;
  logic               armed_q, armed_d;
  logic               ringing_q, ringing_d;
  logic               snoozing_q, snoozing_d;
  logic               trigger;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    cnt_d    = cnt_q;
    buzzer_d = buzzer_q;
    match_d  = (cur_hour == alarm_hour) && (cur_min == alarm_min) && (cur_sec == 6'd0);
    // Rising edge of match only: a held 07:30:00 cannot fire twice.
    trigger  = match_d && !match_q;

    if (!alarm_enable) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF: state_d = ST_ARMED;
        ST_ARMED: begin
          if (trigger) begin
            state_d  = ST_RINGING;
            timer_d  = '0;
            buzzer_d = 1'b1;
            cnt_d    = '0;
          end
        end
        ST_RINGING: begin
          if (stop_btn) begin
            state_d = ST_ARMED;
          end else if (snooze_btn && (cnt_q < CNT_MAX)) begin
            state_d = ST_SNOOZE;
            timer_d = '0;
            cnt_d   = cnt_q + CNT_W'(1);
          end else if (sec_tick) begin
            if (timer_q == RING_LAST) begin
              state_d = ST_ARMED;
            end else begin
              timer_d  = timer_q + TMR_W'(1);
              buzzer_d = !buzzer_q;
            end
          end
        end
        ST_SNOOZE: begin
          if (stop_btn) begin
            state_d = ST_ARMED;
          end else if (sec_tick) begin
            if (timer_q == SNOOZE_LAST) begin
              state_d  = ST_RINGING;
              timer_d  = '0;
              buzzer_d = 1'b1;
            end else begin
              timer_d = timer_q + TMR_W'(1);
            end
          end
        end
        default: state_d = ST_OFF;
      endcase
    end

    if (state_d != ST_RINGING) buzzer_d = 1'b0;

    armed_d    = (state_d == ST_ARMED);
    ringing_d  = (state_d == ST_RINGING);
    snoozing_d = (state_d == ST_SNOOZE);
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q    <= ST_OFF;
      timer_q    <= '0;
      cnt_q      <= '0;
      buzzer_q   <= 1'b0;
      match_q    <= 1'b0;
      armed_q    <= 1'b0;
      ringing_q  <= 1'b0;
      snoozing_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      cnt_q      <= cnt_d;
      buzzer_q   <= buzzer_d;
      match_q    <= match_d;
      armed_q    <= armed_d;
      ringing_q  <= ringing_d;
      snoozing_q <= snoozing_d;
    end
  end

  assign armed      = armed_q;
  assign ringing    = ringing_q;
  assign snoozing   = snoozing_q;
  assign buzzer     = buzzer_q;
  assign snooze_cnt = cnt_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// tb_alarm_sequencer
//   Self-checking bench for alarm_sequencer with RING_SEC=4, SNOOZE_SEC=3
//   and MAX_SNOOZE=2. Each cycle pushes the expected status word
//   {armed, ringing, snoozing, buzzer, snooze_cnt[1:0]} and captures the
//   DUT status one time unit after the edge. Each test task then drains
//   and compares both queues.
module tb_alarm_sequencer;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       sec_tick;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic [5:0] cur_sec;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic       alarm_enable;
  logic       snooze_btn;
  logic       stop_btn;
  logic       armed, ringing, snoozing, buzzer;
  logic [1:0] snooze_cnt;
  logic [1:0] state_dbg;

  logic [5:0] exp_q[$];
  logic [5:0] got_q[$];
  int checks = 0;
  int passed = 0;

  // clock / reset block
  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  alarm_sequencer #(.SNOOZE_SEC(3), .RING_SEC(4), .MAX_SNOOZE(2)) dut (
    .clk_in(clk_in), .reset(reset), .sec_tick(sec_tick),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .alarm_hour(alarm_hour), .alarm_min(alarm_min),
    .alarm_enable(alarm_enable), .snooze_btn(snooze_btn), .stop_btn(stop_btn),
    .armed(armed), .ringing(ringing), .snoozing(snoozing), .buzzer(buzzer),
    .snooze_cnt(snooze_cnt), .state_dbg(state_dbg)
  );

  // driver tasks
  task automatic set_time(input int h, input int m, input int s);
    cur_hour = 5'(h);
    cur_min  = 6'(m);
    cur_sec  = 6'(s);
  endtask

  // One clock with the given pulses. Expected status is queued now and the
  // DUT status is captured just after the edge.
  task automatic cycle(input logic [5:0] exp, input logic tick,
                       input logic snz, input logic stp);
    sec_tick   = tick;
    snooze_btn = snz;
    stop_btn   = stp;
    exp_q.push_back(exp);
    @(posedge clk_in);
    #1;
    got_q.push_back({armed, ringing, snoozing, buzzer, snooze_cnt});
    sec_tick   = 1'b0;
    snooze_btn = 1'b0;
    stop_btn   = 1'b0;
  endtask

  // Produces a fresh match edge: 07:29:59, then 07:30:00.
  task automatic trigger_alarm(input logic [5:0] exp_before, input logic [5:0] exp_after);
    set_time(7, 29, 59);
    cycle(exp_before, 1'b1, 1'b0, 1'b0);
    set_time(7, 30, 0);
    cycle(exp_after, 1'b0, 1'b0, 1'b0);
  endtask

  // Status word: {armed, ringing, snoozing, buzzer, cnt[1:0]}
  task automatic test_reset;
    logic [5:0] e, g;
    reset = 1'b1; alarm_enable = 1'b1; alarm_hour = 5'd7; alarm_min = 6'd30;
    set_time(7, 29, 58);
    cycle(6'b000000, 1'b0, 1'b0, 1'b0);
    cycle(6'b000000, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    cycle(6'b100000, 1'b0, 1'b0, 1'b0);   // OFF -> ARMED
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) $display("FAIL reset[%0d] got=%b exp=%b", i, g, e);
      else passed++;
    end
  endtask

  task automatic test_ring_entry;
    logic [5:0] e, g;
    trigger_alarm(6'b100000, 6'b010100);    // ringing, buzzer=1
    cycle(6'b010100, 1'b0, 1'b0, 1'b0);     // held match does not retrigger
    cycle(6'b010000, 1'b1, 1'b0, 1'b0);     // tick 1: buzzer toggles
    cycle(6'b010000, 1'b0, 1'b0, 1'b0);
    cycle(6'b010100, 1'b1, 1'b0, 1'b0);     // tick 2
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) $display("FAIL ring_entry[%0d] got=%b exp=%b", i, g, e);
      else passed++;
    end
  endtask

  task automatic test_auto_stop;
    logic [5:0] e, g;
    cycle(6'b010000, 1'b1, 1'b0, 1'b0);     // tick 3
    for (int k = 0; k < int'($urandom_range(1, 4)); k++)
      cycle(6'b010000, 1'b0, 1'b0, 1'b0);
    cycle(6'b100000, 1'b1, 1'b0, 1'b0);     // tick 4: auto-stop
    cycle(6'b100000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) $display("FAIL auto_stop[%0d] got=%b exp=%b", i, g, e);
      else passed++;
    end
  endtask

  task automatic test_snooze;
    logic [5:0] e, g;
    trigger_alarm(6'b100000, 6'b010100);
    cycle(6'b001001, 1'b0, 1'b1, 1'b0);     // snooze 1
    cycle(6'b001001, 1'b1, 1'b0, 1'b0);
    cycle(6'b001001, 1'b0, 1'b0, 1'b0);
    cycle(6'b001001, 1'b1, 1'b0, 1'b0);
    cycle(6'b010101, 1'b1, 1'b0, 1'b0);     // 3rd tick: ring again
    cycle(6'b001010, 1'b0, 1'b1, 1'b0);     // snooze 2
    cycle(6'b001010, 1'b1, 1'b0, 1'b0);
    cycle(6'b001010, 1'b1, 1'b0, 1'b0);
    cycle(6'b010110, 1'b1, 1'b0, 1'b0);
    cycle(6'b010110, 1'b0, 1'b1, 1'b0);     // snooze 3 ignored
    cycle(6'b010010, 1'b1, 1'b0, 1'b0);     // still ringing, buzzer toggles
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) $display("FAIL snooze[%0d] got=%b exp=%b", i, g, e);
      else passed++;
    end
  endtask

  task automatic test_stop_and_hold;
    logic [5:0] e, g;
    cycle(6'b100010, 1'b0, 1'b1, 1'b1);     // stop wins over snooze; cnt held
    cycle(6'b100010, 1'b0, 1'b1, 1'b0);     // snooze in ARMED ignored
    for (int k = 0; k < 20; k++)            // 07:30:00 held: no re-ring
      cycle(6'b100010, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) $display("FAIL stop_hold[%0d] got=%b exp=%b", i, g, e);
      else passed++;
    end
  endtask

  task automatic test_disable;
    logic [5:0] e, g;
    trigger_alarm(6'b100010, 6'b010100);    // new trigger clears cnt
    cycle(6'b001001, 1'b0, 1'b1, 1'b0);
    alarm_enable = 1'b0;
    cycle(6'b000001, 1'b1, 1'b0, 1'b1);     // disable beats stop and tick
    cycle(6'b000001, 1'b0, 1'b0, 1'b0);
    alarm_enable = 1'b1;
    cycle(6'b100001, 1'b0, 1'b0, 1'b0);
    trigger_alarm(6'b100001, 6'b010100);    // rings again with cnt=0
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) $display("FAIL disable[%0d] got=%b exp=%b", i, g, e);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_ring;
    logic [5:0] e, g;
    cycle(6'b010000, 1'b1, 1'b0, 1'b0);     // ringing, tick 1
    reset = 1'b1;
    cycle(6'b000000, 1'b1, 1'b0, 1'b0);     // reset wins over tick
    reset = 1'b0;
    cycle(6'b100000, 1'b0, 1'b0, 1'b0);     // match edge seen in OFF: ignored
    cycle(6'b100000, 1'b0, 1'b0, 1'b0);
    cycle(6'b100000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) $display("FAIL reset_mid_ring[%0d] got=%b exp=%b", i, g, e);
      else passed++;
    end
  endtask

  initial begin
    sec_tick = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0;
    reset = 1'b1; alarm_enable = 1'b1;
    alarm_hour = 5'd7; alarm_min = 6'd30;
    set_time(0, 0, 0);
    test_reset();
    test_ring_entry();
    test_auto_stop();
    test_snooze();
    test_stop_and_hold();
    test_disable();
    test_reset_mid_ring();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
